// File: rtl/instr_encoder_loader.sv
// Program loader: turns symbolic RV32I beats into machine words and writes
// them sequentially into instruction memory. Illegal ops and out-of-range
// immediates are flagged instead of written.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              enc_err,
  output logic [ADDR_W-1:0] err_index,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {F_U, F_J, F_I, F_S, F_B, F_R, F_SH, F_BAD} fmt_t;

  typedef struct packed {
    fmt_t       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
  } dec_t;

  // Counter is one bit wider than the address so it can hold DEPTH itself.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic signed [31:0] imm_s;
  dec_t              dec_p0;
  logic              legal_p0;
  logic [31:0]       enc_p0;
  logic              accept_p0;

  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    d = '{fmt: F_BAD, opc: 7'h00, f3: 3'd0, f7: 7'h00};
    case (op)
      6'd0:  begin d.fmt = F_U;  d.opc = 7'h37; end
      6'd1:  begin d.fmt = F_U;  d.opc = 7'h17; end
      6'd2:  begin d.fmt = F_J;  d.opc = 7'h6F; end
      6'd3:  begin d.fmt = F_I;  d.opc = 7'h67; d.f3 = 3'd0; end
      6'd4:  begin d.fmt = F_B;  d.opc = 7'h63; d.f3 = 3'd0; end
      6'd5:  begin d.fmt = F_B;  d.opc = 7'h63; d.f3 = 3'd1; end
      6'd6:  begin d.fmt = F_B;  d.opc = 7'h63; d.f3 = 3'd4; end
      6'd7:  begin d.fmt = F_B;  d.opc = 7'h63; d.f3 = 3'd5; end
      6'd8:  begin d.fmt = F_B;  d.opc = 7'h63; d.f3 = 3'd6; end
      6'd9:  begin d.fmt = F_B;  d.opc = 7'h63; d.f3 = 3'd7; end
      6'd10: begin d.fmt = F_I;  d.opc = 7'h03; d.f3 = 3'd0; end
      6'd11: begin d.fmt = F_I;  d.opc = 7'h03; d.f3 = 3'd1; end
      6'd12: begin d.fmt = F_I;  d.opc = 7'h03; d.f3 = 3'd2; end
      6'd13: begin d.fmt = F_I;  d.opc = 7'h03; d.f3 = 3'd4; end
      6'd14: begin d.fmt = F_I;  d.opc = 7'h03; d.f3 = 3'd5; end
      6'd15: begin d.fmt = F_S;  d.opc = 7'h23; d.f3 = 3'd0; end
      6'd16: begin d.fmt = F_S;  d.opc = 7'h23; d.f3 = 3'd1; end
      6'd17: begin d.fmt = F_S;  d.opc = 7'h23; d.f3 = 3'd2; end
      6'd18: begin d.fmt = F_I;  d.opc = 7'h13; d.f3 = 3'd0; end
      6'd19: begin d.fmt = F_I;  d.opc = 7'h13; d.f3 = 3'd2; end
      6'd20: begin d.fmt = F_I;  d.opc = 7'h13; d.f3 = 3'd3; end
      6'd21: begin d.fmt = F_I;  d.opc = 7'h13; d.f3 = 3'd4; end
      6'd22: begin d.fmt = F_I;  d.opc = 7'h13; d.f3 = 3'd6; end
      6'd23: begin d.fmt = F_I;  d.opc = 7'h13; d.f3 = 3'd7; end
      6'd24: begin d.fmt = F_SH; d.opc = 7'h13; d.f3 = 3'd1; end
      6'd25: begin d.fmt = F_SH; d.opc = 7'h13; d.f3 = 3'd5; end
      6'd26: begin d.fmt = F_SH; d.opc = 7'h13; d.f3 = 3'd5; d.f7 = 7'h20; end
      6'd27: begin d.fmt = F_R;  d.opc = 7'h33; d.f3 = 3'd0; end
      6'd28: begin d.fmt = F_R;  d.opc = 7'h33; d.f3 = 3'd0; d.f7 = 7'h20; end
      6'd29: begin d.fmt = F_R;  d.opc = 7'h33; d.f3 = 3'd1; end
      6'd30: begin d.fmt = F_R;  d.opc = 7'h33; d.f3 = 3'd2; end
      6'd31: begin d.fmt = F_R;  d.opc = 7'h33; d.f3 = 3'd3; end
      6'd32: begin d.fmt = F_R;  d.opc = 7'h33; d.f3 = 3'd4; end
      6'd33: begin d.fmt = F_R;  d.opc = 7'h33; d.f3 = 3'd5; end
      6'd34: begin d.fmt = F_R;  d.opc = 7'h33; d.f3 = 3'd5; d.f7 = 7'h20; end
      6'd35: begin d.fmt = F_R;  d.opc = 7'h33; d.f3 = 3'd6; end
      6'd36: begin d.fmt = F_R;  d.opc = 7'h33; d.f3 = 3'd7; end
      default: d.fmt = F_BAD;
    endcase
    return d;
  endfunction

  // Immediate range check per instruction format.
  function automatic logic imm_ok(input fmt_t f, input logic signed [31:0] imm);
    case (f)
      F_U:      return imm[11:0] == 12'd0;
      F_J:      return (imm >= -32'sd1048576) && (imm <= 32'sd1048574) && !imm[0];
      F_I, F_S: return (imm >= -32'sd2048) && (imm <= 32'sd2047);
      F_B:      return (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
      F_SH:     return imm[31:5] == 27'd0;
      F_R:      return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] encode(input dec_t d, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic signed [31:0] imm);
    case (d.fmt)
      F_U:     return {imm[31:12], rd, d.opc};
      F_J:     return {imm[20], imm[10:1], imm[11], imm[19:12], rd, d.opc};
      F_I:     return {imm[11:0], rs1, d.f3, rd, d.opc};
      F_S:     return {imm[11:5], rs2, rs1, d.f3, imm[4:0], d.opc};
      F_B:     return {imm[12], imm[10:5], rs2, rs1, d.f3, imm[4:1], imm[11], d.opc};
      F_R:     return {d.f7, rs2, rs1, d.f3, rd, d.opc};
      F_SH:    return {d.f7, imm[4:0], rs1, d.f3, rd, d.opc};
      default: return 32'd0;
    endcase
  endfunction

  // Stage p0: combinational decode/encode of the presented beat.
  assign imm_s     = $signed(in_imm);
  assign dec_p0    = decode(in_op);
  assign legal_p0  = imm_ok(dec_p0.fmt, imm_s);
  assign enc_p0    = encode(dec_p0, in_rd, in_rs1, in_rs2, imm_s);
  assign busy      = (state == RUN);
  assign in_ready  = (state == RUN) && (cnt < DEPTH_C);
  assign accept_p0 = in_valid && in_ready;

  // Session FSM, word counter, error flags and the registered write port (stage p1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      done       <= 1'b0;
      enc_err    <= 1'b0;
      err_index  <= '0;
      overflow   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            cnt       <= '0;
            done      <= 1'b0;
            enc_err   <= 1'b0;
            err_index <= '0;
            overflow  <= 1'b0;
          end
        end
        RUN: begin
          if (accept_p0) begin
            if (legal_p0) begin
              imem_we    <= 1'b1;
              imem_addr  <= cnt[ADDR_W-1:0];
              imem_wdata <= enc_p0;
              cnt        <= cnt + 1'b1;
            end else begin
              enc_err <= 1'b1;
              if (!enc_err) err_index <= cnt[ADDR_W-1:0];
            end
            // in_last wins over overflow when the final word fills memory.
            if (in_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (legal_p0 && ((cnt + 1'b1) == DEPTH_C)) begin
              state    <= DONE;
              done     <= 1'b1;
              overflow <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed program sessions, a transaction
// level reference model compared every cycle, plus literal encodings.
module tb_instr_encoder_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [5:0]        in_op = '0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]       in_imm = '0;
  logic              in_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done, enc_err, overflow;
  logic [ADDR_W-1:0] err_index;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .enc_err(enc_err), .err_index(err_index), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int br_f3 [6]  = '{0, 1, 4, 5, 6, 7};
  int ld_f3 [5]  = '{0, 1, 2, 4, 5};
  int ai_f3 [6]  = '{0, 2, 3, 4, 6, 7};
  int r_f3  [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

  function automatic void model_enc(input int op, input int rd, input int rs1, input int rs2,
                                    input logic [31:0] imm, output bit ok, output logic [31:0] w);
    int v, x, f3, opc;
    v = $signed(imm);
    x = 0;
    ok = 1'b0;
    if (op == 0 || op == 1) begin
      ok = (v % 4096) == 0;
      x = (v & 'hFFFFF000) | (rd << 7) | ((op == 0) ? 'h37 : 'h17);
    end else if (op == 2) begin
      ok = (v >= -(1 << 20)) && (v <= (1 << 20) - 2) && (v % 2 == 0);
      x = (((v >> 20) & 1) << 31) | (((v >> 1) & 'h3FF) << 21) | (((v >> 11) & 1) << 20) |
          (((v >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
    end else if (op == 3 || (op >= 10 && op <= 14) || (op >= 18 && op <= 23)) begin
      ok = (v >= -2048) && (v <= 2047);
      opc = (op == 3) ? 'h67 : (op <= 14) ? 'h03 : 'h13;
      f3 = (op == 3) ? 0 : (op <= 14) ? ld_f3[op-10] : ai_f3[op-18];
      x = ((v & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
    end else if (op >= 15 && op <= 17) begin
      ok = (v >= -2048) && (v <= 2047);
      x = (((v >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | ((op - 15) << 12) |
          ((v & 31) << 7) | 'h23;
    end else if (op >= 4 && op <= 9) begin
      ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      x = (((v >> 12) & 1) << 31) | (((v >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15) |
          (br_f3[op-4] << 12) | (((v >> 1) & 15) << 8) | (((v >> 11) & 1) << 7) | 'h63;
    end else if (op >= 24 && op <= 26) begin
      ok = (v >= 0) && (v <= 31);
      x = (((op == 26) ? 32 : 0) << 25) | ((v & 31) << 20) | (rs1 << 15) |
          (((op == 24) ? 1 : 5) << 12) | (rd << 7) | 'h13;
    end else if (op >= 27 && op <= 36) begin
      ok = 1'b1;
      x = (((op == 28 || op == 34) ? 32 : 0) << 25) | (rs2 << 20) | (rs1 << 15) |
          (r_f3[op-27] << 12) | (rd << 7) | 'h33;
    end
    w = x;
  endfunction

  bit          m_run, m_done, m_err, m_ovf, m_we, m_ok;
  int          m_cnt;
  logic [7:0]  m_eidx, m_addr;
  logic [31:0] m_wdata, m_w;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_done = 0; m_err = 0; m_ovf = 0; m_we = 0;
      m_cnt = 0; m_eidx = 0; m_addr = 0; m_wdata = 0;
    end else begin
      m_we = 0;
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_cnt = 0; m_done = 0; m_err = 0; m_eidx = 0; m_ovf = 0;
        end
      end else if (in_valid && m_cnt < DEPTH) begin
        model_enc(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), in_imm, m_ok, m_w);
        if (m_ok) begin
          m_we = 1; m_addr = 8'(m_cnt); m_wdata = m_w; m_cnt++;
        end else begin
          if (!m_err) m_eidx = 8'(m_cnt);
          m_err = 1;
        end
        if (in_last) begin
          m_run = 0; m_done = 1;
        end else if (m_cnt == DEPTH) begin
          m_run = 0; m_done = 1; m_ovf = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("we", 40'(imem_we), 40'(m_we));
    chk("addr", 40'(imem_addr), 40'(m_addr));
    chk("wdata", 40'(imem_wdata), 40'(m_wdata));
    chk("in_ready", 40'(in_ready), 40'(m_run && (m_cnt < DEPTH)));
    chk("busy", 40'(busy), 40'(m_run));
    chk("done", 40'(done), 40'(m_done));
    chk("enc_err", 40'(enc_err), 40'(m_err));
    chk("err_index", 40'(err_index), 40'(m_eidx));
    chk("overflow", 40'(overflow), 40'(m_ovf));
  end

  // Log of writes for literal checks.
  logic [39:0] wlog [$];
  always @(negedge clk) if (imem_we === 1'b1) wlog.push_back({imem_addr, imem_wdata});

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    wlog.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_beat(input int op, input int rd, input int rs1, input int rs2,
                          input logic [31:0] imm, input bit last);
    in_op = 6'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_imm = imm; in_last = last; in_valid = 1'b1;
  endtask

  task automatic beat(input int op, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm, input bit last);
    set_beat(op, rd, rs1, rs2, imm, last);
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_we", 40'(imem_we), 40'd0);
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_ready", 40'(in_ready), 40'd0);
    chk("rst_done", 40'(done), 40'd0);

    // Single ADDI
    do_start();
    beat(18, 1, 0, 0, 32'd5, 1);
    idle(1);
    chk("addi_cnt", 40'(wlog.size()), 40'd1);
    chk("addi", wlog[0], {8'd0, 32'h00500093});

    // Back-to-back R/I/S, last word exactly fills memory
    do_start();
    beat(27, 3, 1, 2, 32'd0, 0);
    beat(28, 3, 1, 2, 32'd0, 0);
    beat(12, 5, 2, 0, 32'd8, 0);
    beat(17, 0, 2, 5, 32'd12, 1);
    idle(1);
    chk("b2b_cnt", 40'(wlog.size()), 40'd4);
    chk("add", wlog[0], {8'd0, 32'h002081B3});
    chk("sub", wlog[1], {8'd1, 32'h402081B3});
    chk("lw", wlog[2], {8'd2, 32'h00812283});
    chk("sw", wlog[3], {8'd3, 32'h00512623});
    chk("b2b_ovf", 40'(overflow), 40'd0);

    // BEQ with last, then LUI in a new session
    do_start();
    beat(4, 0, 1, 2, -32'sd4, 1);
    chk("beq_done", 40'(done), 40'd1);
    chk("beq_busy", 40'(busy), 40'd0);
    idle(1);
    chk("beq", wlog[0], {8'd0, 32'hFE208EE3});
    do_start();
    beat(0, 1, 0, 0, 32'h12345000, 1);
    idle(1);
    chk("lui", wlog[0], {8'd0, 32'h123450B7});

    // Illegal beats
    do_start();
    beat(18, 1, 0, 0, 32'd1, 0);
    beat(18, 2, 0, 0, 32'd2, 0);
    beat(40, 1, 1, 1, 32'd0, 0);
    chk("ill_err", 40'(enc_err), 40'd1);
    chk("ill_idx", 40'(err_index), 40'd2);
    chk("ill_we", 40'(imem_we), 40'd0);
    beat(18, 3, 0, 0, 32'd2048, 0);
    chk("ill2_idx", 40'(err_index), 40'd2);
    chk("ill2_we", 40'(imem_we), 40'd0);
    beat(22, 4, 1, 0, 32'd15, 1);
    idle(1);
    chk("ill_cnt", 40'(wlog.size()), 40'd3);
    chk("ori", wlog[2], {8'd2, 32'h00F0E213});

    // Overflow: five beats, no last; start during RUN is ignored
    do_start();
    beat(27, 1, 2, 3, 32'd0, 0);
    start = 1'b1;
    beat(27, 2, 2, 3, 32'd0, 0);
    start = 1'b0;
    beat(27, 3, 2, 3, 32'd0, 0);
    beat(27, 4, 2, 3, 32'd0, 0);
    chk("ovf_ready", 40'(in_ready), 40'd0);
    chk("ovf_flag", 40'(overflow), 40'd1);
    chk("ovf_done", 40'(done), 40'd1);
    beat(27, 5, 2, 3, 32'd0, 0);
    idle(2);
    chk("ovf_cnt", 40'(wlog.size()), 40'd4);

    // Mixed formats, boundary immediates (model-checked)
    do_start();
    beat(2, 1, 0, 0, 32'd2048, 0);
    beat(3, 1, 2, 0, -32'sd2048, 0);
    idle(1);
    beat(1, 5, 0, 0, 32'hFFFFF000, 0);
    beat(26, 6, 7, 0, 32'd31, 1);
    idle(1);
    chk("jal", wlog[0], {8'd0, 32'h001000EF});
    do_start();
    beat(2, 1, 0, 0, 32'd3, 0);
    beat(9, 0, 1, 2, 32'd4096, 0);
    beat(24, 1, 2, 0, 32'd32, 0);
    beat(0, 1, 0, 0, 32'h00000800, 0);
    beat(18, 1, 0, 0, -32'sd2049, 0);
    beat(9, 0, 3, 4, 32'd4094, 0);
    beat(6, 0, 3, 4, -32'sd4096, 0);
    beat(15, 0, 5, 6, 32'd2047, 0);
    beat(14, 7, 8, 0, -32'sd2048, 1);
    idle(1);
    do_start();
    beat(29, 1, 2, 3, 32'd0, 0);
    beat(30, 4, 5, 6, 32'd0, 0);
    beat(31, 7, 8, 9, 32'd0, 0);
    beat(32, 10, 11, 12, 32'd0, 1);
    idle(1);
    do_start();
    beat(33, 13, 14, 15, 32'd0, 0);
    beat(34, 16, 17, 18, 32'd0, 0);
    beat(35, 19, 20, 21, 32'd0, 0);
    beat(36, 31, 30, 29, 32'd0, 1);
    idle(1);
    do_start();
    beat(19, 1, 2, 0, -32'sd1, 0);
    beat(20, 3, 4, 0, 32'd2047, 0);
    beat(21, 5, 6, 0, 32'h000005A5, 0);
    beat(23, 7, 8, 0, 32'd255, 1);
    idle(1);
    do_start();
    beat(25, 1, 2, 0, 32'd17, 0);
    beat(5, 0, 1, 2, 32'd2, 0);
    beat(7, 0, 3, 4, -32'sd2, 0);
    beat(8, 0, 5, 6, 32'd2048, 1);
    idle(1);
    do_start();
    beat(10, 1, 2, 0, 32'd1, 0);
    beat(11, 2, 3, 0, -32'sd100, 0);
    beat(13, 3, 4, 0, 32'd0, 0);
    beat(16, 0, 5, 6, -32'sd32, 1);
    idle(1);
    do_start();
    beat(2, 1, 0, 0, 32'd1048574, 0);
    beat(2, 2, 0, 0, -32'sd1048576, 0);
    beat(2, 3, 0, 0, 32'd1048576, 0);
    beat(63, 0, 0, 0, 32'd0, 1);
    idle(1);
    chk("ill_last_done", 40'(done), 40'd1);
    chk("ill_last_idx", 40'(err_index), 40'd2);

    // Reset mid-session
    do_start();
    beat(18, 1, 0, 0, 32'd5, 0);
    set_beat(27, 3, 1, 2, 32'd0, 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_we", 40'(imem_we), 40'd0);
    chk("mid_wdata", 40'(imem_wdata), 40'd0);
    chk("mid_busy", 40'(busy), 40'd0);
    chk("mid_ready", 40'(in_ready), 40'd0);
    tick();
    chk("mid_we2", 40'(imem_we), 40'd0);
    reset = 1'b0;
    idle(1);
    do_start();
    beat(18, 2, 0, 0, 32'd7, 1);
    idle(1);
    chk("post_rst", wlog[0], {8'd0, 32'h00700113});

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
